// File: rtl/cv32e40p_rf_wb_arbiter.sv
// Write-back arbiter: shares the two register file write ports among NUM_REQ sources,
// granting up to two distinct-address writers per cycle in round-robin order.
module cv32e40p_rf_wb_arbiter #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    output logic [ADDR_WIDTH-1:0]                waddr_a_o,
    output logic [DATA_WIDTH-1:0]                wdata_a_o,
    output logic                                 we_a_o,
    output logic [ADDR_WIDTH-1:0]                waddr_b_o,
    output logic [DATA_WIDTH-1:0]                wdata_b_o,
    output logic                                 we_b_o,
    output logic [2**ADDR_WIDTH-1:0]             wb_pending_o
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   g1Found, g2Found;
    logic [PTR_W-1:0]       g1Idx, g2Idx;

    logic [ADDR_WIDTH-1:0]  waddr_a_q, waddr_b_q;
    logic [DATA_WIDTH-1:0]  wdata_a_q, wdata_b_q;
    logic                   we_a_q, we_b_q;

    function automatic logic [PTR_W-1:0] wrapInc(input logic [PTR_W-1:0] idx);
        if (32'(idx) == NUM_REQ - 1) begin
            return '0;
        end
        return idx + PTR_W'(1);
    endfunction

    // Scan from the pointer; the second grant skips anyone aiming at the first grant's register.
    always_comb begin
        logic [PTR_W-1:0] scanIdx;
        g1Found = 1'b0;
        g2Found = 1'b0;
        g1Idx   = '0;
        g2Idx   = '0;
        scanIdx = rr_ptr_q;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (req_valid_i[scanIdx]) begin
                if (!g1Found) begin
                    g1Found = 1'b1;
                    g1Idx   = scanIdx;
                end else if (!g2Found && (req_addr_i[scanIdx] != req_addr_i[g1Idx])) begin
                    g2Found = 1'b1;
                    g2Idx   = scanIdx;
                end
            end
            scanIdx = wrapInc(scanIdx);
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (g1Found) begin
            req_ready_o[g1Idx] = 1'b1;
        end
        if (g2Found) begin
            req_ready_o[g2Idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (g2Found) begin
            rr_ptr_d = wrapInc(g2Idx);
        end else if (g1Found) begin
            rr_ptr_d = wrapInc(g1Idx);
        end
    end

    // Port B is the register file's priority port, so it always takes the first grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            waddr_a_q <= '0;
            wdata_a_q <= '0;
            we_a_q    <= 1'b0;
            waddr_b_q <= '0;
            wdata_b_q <= '0;
            we_b_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            we_b_q   <= 1'b0;
            we_a_q   <= 1'b0;
            if (g1Found) begin
                waddr_b_q <= req_addr_i[g1Idx];
                wdata_b_q <= req_data_i[g1Idx];
                we_b_q    <= (req_addr_i[g1Idx] != '0);
            end
            if (g2Found) begin
                waddr_a_q <= req_addr_i[g2Idx];
                wdata_a_q <= req_data_i[g2Idx];
                we_a_q    <= (req_addr_i[g2Idx] != '0);
            end
        end
    end

    assign waddr_a_o = waddr_a_q;
    assign wdata_a_o = wdata_a_q;
    assign we_a_o    = we_a_q;
    assign waddr_b_o = waddr_b_q;
    assign wdata_b_o = wdata_b_q;
    assign we_b_o    = we_b_q;

    always_comb begin
        wb_pending_o = '0;
        if (we_a_q) begin
            wb_pending_o[waddr_a_q] = 1'b1;
        end
        if (we_b_q) begin
            wb_pending_o[waddr_b_q] = 1'b1;
        end
    end

    noSameAddrWrite : assert property (@(posedge clk) disable iff (rst)
        !(we_a_q && we_b_q && (waddr_a_q == waddr_b_q)));

endmodule

// File: tb/tb_cv32e40p_rf_wb_arbiter.sv
// Directed bench for cv32e40p_rf_wb_arbiter: hand-computed grants, port contents and
// pending bits across reset, round robin, conflicts, x0 writes and reset mid-stream.
module tb_cv32e40p_rf_wb_arbiter;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [3:0]           reqValid;
    logic [3:0][5:0]      reqAddr;
    logic [3:0][31:0]     reqData;
    logic [3:0]           reqReady;
    logic [5:0]           waddrA, waddrB;
    logic [31:0]          wdataA, wdataB;
    logic                 weA, weB;
    logic [63:0]          pending;

    int checkCount = 0;
    int passCount  = 0;

    cv32e40p_rf_wb_arbiter #(
        .ADDR_WIDTH (6),
        .DATA_WIDTH (32),
        .NUM_REQ    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (reqValid),
        .req_addr_i   (reqAddr),
        .req_data_i   (reqData),
        .req_ready_o  (reqReady),
        .waddr_a_o    (waddrA),
        .wdata_a_o    (wdataA),
        .we_a_o       (weA),
        .waddr_b_o    (waddrB),
        .wdata_b_o    (wdataB),
        .we_b_o       (weB),
        .wb_pending_o (pending)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] dataOf(input int idx, input int addr);
        return 32'(32'h1000_0000 * (idx + 1) + addr);
    endfunction

    // Inputs change 1 time unit after a rising edge; ready is checked once they settle.
    task automatic applyStimulus(input logic rstVal, input logic [3:0] valid,
                                 input int a0, input int a1, input int a2, input int a3);
        int a [4];
        a = '{a0, a1, a2, a3};
        rst      = rstVal;
        reqValid = valid;
        for (int i = 0; i < 4; i++) begin
            reqAddr[i] = 6'(a[i]);
            reqData[i] = dataOf(i, a[i]);
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReady(input string tag, input logic [3:0] expected);
        checkOutput({tag, ".ready"}, 64'(reqReady), 64'(expected));
    endtask

    task automatic checkPorts(input string tag,
                              input logic weBExp, input int addrBExp, input logic [31:0] dataBExp,
                              input logic weAExp, input int addrAExp, input logic [31:0] dataAExp);
        checkOutput({tag, ".we_b"},    64'(weB),    64'(weBExp));
        checkOutput({tag, ".waddr_b"}, 64'(waddrB), 64'(addrBExp));
        checkOutput({tag, ".wdata_b"}, 64'(wdataB), 64'(dataBExp));
        checkOutput({tag, ".we_a"},    64'(weA),    64'(weAExp));
        checkOutput({tag, ".waddr_a"}, 64'(waddrA), 64'(addrAExp));
        checkOutput({tag, ".wdata_a"}, 64'(wdataA), 64'(dataAExp));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        reqValid = '0;
        reqAddr  = '0;
        reqData  = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset held with all requesters valid
        applyStimulus(1'b1, 4'b1111, 1, 2, 3, 4);
        checkReady("rst", 4'b0011);
        tick();
        checkPorts("rst_hold", 1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
        checkOutput("rst_pending", pending, 64'h0);

        applyStimulus(1'b0, 4'b1111, 1, 2, 3, 4);
        checkReady("post_rst", 4'b0011);
        tick();
        checkPorts("post_rst", 1'b1, 1, dataOf(0, 1), 1'b1, 2, dataOf(1, 2));
        checkOutput("post_rst_pending", pending, 64'h6);

        // Round robin, pointer now at 2
        applyStimulus(1'b0, 4'b1111, 5, 6, 7, 8);
        checkReady("rr0", 4'b1100);
        tick();
        checkPorts("rr0", 1'b1, 7, dataOf(2, 7), 1'b1, 8, dataOf(3, 8));
        checkReady("rr1", 4'b0011);
        tick();
        checkPorts("rr1", 1'b1, 5, dataOf(0, 5), 1'b1, 6, dataOf(1, 6));
        checkReady("rr2", 4'b1100);
        tick();
        checkPorts("rr2", 1'b1, 7, dataOf(2, 7), 1'b1, 8, dataOf(3, 8));

        // Address conflict, pointer at 0
        applyStimulus(1'b0, 4'b0111, 9, 9, 10, 0);
        checkReady("conf0", 4'b0101);
        tick();
        checkPorts("conf0", 1'b1, 9, dataOf(0, 9), 1'b1, 10, dataOf(2, 10));
        checkOutput("conf0_pending", pending, (64'd1 << 9) | (64'd1 << 10));
        applyStimulus(1'b0, 4'b0010, 9, 9, 10, 0);
        checkReady("conf1", 4'b0010);
        tick();
        checkPorts("conf1", 1'b1, 9, dataOf(1, 9), 1'b0, 10, dataOf(2, 10));
        checkOutput("conf1_pending", pending, 64'd1 << 9);

        // Write to x0 from req3, pointer at 2
        applyStimulus(1'b0, 4'b1000, 0, 0, 0, 0);
        reqData[3] = 32'hDEAD_BEEF;
        checkReady("x0", 4'b1000);
        tick();
        checkPorts("x0", 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 10, dataOf(2, 10));
        checkOutput("x0_pending", pending, 64'h0);

        // Pointer must have wrapped to 0
        applyStimulus(1'b0, 4'b1111, 30, 31, 32, 33);
        checkReady("x0_ptr", 4'b0011);
        tick();
        checkPorts("x0_ptr", 1'b1, 30, dataOf(0, 30), 1'b1, 31, dataOf(1, 31));

        // Back-pressure on req1, pointer at 2
        applyStimulus(1'b0, 4'b0111, 20, 21, 22, 0);
        checkReady("bp0", 4'b0101);
        tick();
        checkPorts("bp0", 1'b1, 22, dataOf(2, 22), 1'b1, 20, dataOf(0, 20));
        applyStimulus(1'b0, 4'b0111, 23, 21, 24, 0);
        checkReady("bp1", 4'b0110);
        tick();
        checkPorts("bp1", 1'b1, 21, dataOf(1, 21), 1'b1, 24, dataOf(2, 24));
        applyStimulus(1'b0, 4'b0101, 23, 21, 25, 0);
        checkReady("bp2", 4'b0101);
        tick();
        checkPorts("bp2", 1'b1, 23, dataOf(0, 23), 1'b1, 25, dataOf(2, 25));

        // Everyone on the same register, pointer at 3
        applyStimulus(1'b0, 4'b1111, 40, 40, 40, 40);
        checkReady("same0", 4'b1000);
        tick();
        checkPorts("same0", 1'b1, 40, dataOf(3, 40), 1'b0, 25, dataOf(2, 25));
        applyStimulus(1'b0, 4'b0111, 40, 40, 40, 40);
        checkReady("same1", 4'b0001);
        tick();
        checkPorts("same1", 1'b1, 40, dataOf(0, 40), 1'b0, 25, dataOf(2, 25));
        checkOutput("same1_pending", pending, 64'd1 << 40);

        // Reset mid-stream, pointer at 1
        applyStimulus(1'b0, 4'b0011, 11, 12, 0, 0);
        checkReady("mid0", 4'b0011);
        tick();
        checkPorts("mid0", 1'b1, 12, dataOf(1, 12), 1'b1, 11, dataOf(0, 11));
        applyStimulus(1'b1, 4'b0011, 13, 14, 0, 0);
        checkReady("mid_rst", 4'b0011);
        tick();
        checkPorts("mid_rst", 1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
        checkOutput("mid_rst_pending", pending, 64'h0);
        applyStimulus(1'b0, 4'b0000, 0, 0, 0, 0);
        checkReady("mid_idle", 4'b0000);
        tick();
        checkPorts("mid_idle", 1'b0, 0, 32'h0, 1'b0, 0, 32'h0);

        // Pointer must be back at 0: req0 takes port B ahead of req3
        applyStimulus(1'b0, 4'b1001, 15, 0, 0, 18);
        checkReady("mid_ptr", 4'b1001);
        tick();
        checkPorts("mid_ptr", 1'b1, 15, dataOf(0, 15), 1'b1, 18, dataOf(3, 18));
        applyStimulus(1'b0, 4'b0000, 0, 0, 0, 0);
        tick();
        checkPorts("drain", 1'b0, 15, dataOf(0, 15), 1'b0, 18, dataOf(3, 18));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
